// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: command-memory read port, decoder handshake,
// jump redirect and fault flag of the instruction fetch unit.
interface instr_fetch_unit_if;
  logic [12:0] mem_address;
  logic        mem_read;
  logic [7:0]  mem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_hi;
  logic [7:0]  instr_lo;
  logic        instr_len2;
  logic [12:0] instr_pc;
  logic        jump_en;
  logic [12:0] jump_addr;
  logic        fault;

  // fetch unit side
  modport master (
    output mem_address,
    output mem_read,
    input  mem_data,
    output instr_valid,
    input  instr_ready,
    output instr_hi,
    output instr_lo,
    output instr_len2,
    output instr_pc,
    input  jump_en,
    input  jump_addr,
    output fault
  );

  // memory / control-unit side
  modport slave (
    input  mem_address,
    input  mem_read,
    output mem_data,
    input  instr_valid,
    output instr_ready,
    input  instr_hi,
    input  instr_lo,
    input  instr_len2,
    input  instr_pc,
    output jump_en,
    output jump_addr,
    input  fault
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches 1/2-byte instructions from 8-bit memory.
// FETCH_WRAP_FAULT_EN: halt with fault=1 on a 13-bit address wrap.
module instr_fetch_unit #(
  parameter logic [12:0] RESET_PC  = 13'd0,
  parameter int unsigned READ_WAIT = 0
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);

`ifdef FETCH_WRAP_FAULT_EN
  localparam bit WRAP_FAULT = 1'b1;
`else
  localparam bit WRAP_FAULT = 1'b0;
`endif

  localparam logic [2:0] WLAST = 3'(READ_WAIT);

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD2,
    ISSUE,
    HALT
  } state_t;

  state_t      state;
  logic [12:0] pc;
  logic [2:0]  wcnt;

  logic        b1_len2;
  logic [13:0] inc1;
  logic [13:0] inc_len;
  logic        wait_done;

  // length of the instruction whose first byte is on mem_data
  always_comb begin
    b1_len2 = 1'b1;
    unique case (bus.mem_data[7:5])
      3'b100,
      3'b101,
      3'b111:  b1_len2 = 1'b0;
      default: b1_len2 = 1'b1;
    endcase
  end

  assign inc1      = {1'b0, pc} + 14'd1;
  assign inc_len   = {1'b0, pc}
                   + (bus.instr_len2 ? 14'd2 : 14'd1);
  assign wait_done = (wcnt == WLAST);

  // fetch FSM; all bus outputs are registered here
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      wcnt            <= '0;
      bus.mem_address <= '0;
      bus.mem_read    <= 1'b0;
      bus.instr_valid <= 1'b0;
      bus.instr_hi    <= '0;
      bus.instr_lo    <= '0;
      bus.instr_len2  <= 1'b0;
      bus.instr_pc    <= '0;
      bus.fault       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state        <= RD1;
          wcnt         <= '0;
          bus.mem_read <= 1'b1;
          if (bus.jump_en) begin
            pc              <= bus.jump_addr;
            bus.mem_address <= bus.jump_addr;
          end else begin
            bus.mem_address <= pc;
          end
        end

        RD1, RD2: begin
          if (bus.jump_en) begin
            pc              <= bus.jump_addr;
            bus.mem_address <= bus.jump_addr;
            bus.mem_read    <= 1'b1;
            wcnt            <= '0;
            state           <= RD1;
          end else if (!wait_done) begin
            wcnt <= wcnt + 3'd1;
          end else begin
            wcnt <= '0;
            if (state == RD1) begin
              bus.instr_hi <= bus.mem_data;
              bus.instr_pc <= pc;
              if (!b1_len2) begin
                bus.instr_lo    <= '0;
                bus.instr_len2  <= 1'b0;
                bus.instr_valid <= 1'b1;
                bus.mem_read    <= 1'b0;
                state           <= ISSUE;
              end else if (WRAP_FAULT && inc1[13]) begin
                bus.fault    <= 1'b1;
                bus.mem_read <= 1'b0;
                state        <= HALT;
              end else begin
                bus.instr_len2  <= 1'b1;
                bus.mem_address <= inc1[12:0];
                state           <= RD2;
              end
            end else begin
              bus.instr_lo    <= bus.mem_data;
              bus.instr_valid <= 1'b1;
              bus.mem_read    <= 1'b0;
              state           <= ISSUE;
            end
          end
        end

        ISSUE: begin
          if (bus.instr_ready) begin
            bus.instr_valid <= 1'b0;
            if (bus.jump_en) begin
              pc              <= bus.jump_addr;
              bus.mem_address <= bus.jump_addr;
              bus.mem_read    <= 1'b1;
              wcnt            <= '0;
              state           <= RD1;
            end else if (WRAP_FAULT && inc_len[13]) begin
              bus.fault <= 1'b1;
              state     <= HALT;
            end else begin
              pc              <= inc_len[12:0];
              bus.mem_address <= inc_len[12:0];
              bus.mem_read    <= 1'b1;
              wcnt            <= '0;
              state           <= RD1;
            end
          end else if (bus.jump_en) begin
            bus.instr_valid <= 1'b0;
            pc              <= bus.jump_addr;
            bus.mem_address <= bus.jump_addr;
            bus.mem_read    <= 1'b1;
            wcnt            <= '0;
            state           <= RD1;
          end
        end

        HALT: begin
          bus.mem_read    <= 1'b0;
          bus.instr_valid <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
